// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion scheduler: serially steps every slot once per enabled vsync edge
// through a shared adder/bounds checker, then publishes a double-buffered position set.
module sprite_motion_ctrl #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SCREEN_W    = 1280,
  parameter int unsigned SCREEN_H    = 720,
  parameter int unsigned SPRITE_SIZE = 128
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_v_sync,
  input  logic                      i_enable,
  input  logic                      i_cfg_we,
  input  logic [3:0]                i_cfg_idx,
  input  logic [15:0]               i_cfg_x,
  input  logic [15:0]               i_cfg_y,
  input  logic [7:0]                i_cfg_dx,
  input  logic [7:0]                i_cfg_dy,
  input  logic                      i_cfg_bounce,
  output logic [16*NUM_SPRITES-1:0] o_pos_x,
  output logic [16*NUM_SPRITES-1:0] o_pos_y,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [15:0]               o_frame_cnt,
  output logic                      o_overrun
);

  localparam int unsigned IdxW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [15:0] MaxX = 16'(SCREEN_W - SPRITE_SIZE);
  localparam logic [15:0] MaxY = 16'(SCREEN_H - SPRITE_SIZE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {StIdle, StUpdate, StPublish} state_e;

  state_e          state;
  logic [IdxW-1:0] idx;
  logic            pending;

  logic vs_meta, vs_sync, vs_prev, vs_edge;

  // Working slot state
  logic [15:0] pos_x  [NUM_SPRITES];
  logic [15:0] pos_y  [NUM_SPRITES];
  logic [15:0] home_x [NUM_SPRITES];
  logic [15:0] home_y [NUM_SPRITES];
  logic [7:0]  vel_dx [NUM_SPRITES];
  logic [7:0]  vel_dy [NUM_SPRITES];
  logic        bounce [NUM_SPRITES];

  logic            cfg_hit;
  logic [IdxW-1:0] cfg_slot;

  logic [15:0] cur_x, cur_y, cur_hx, cur_hy;
  logic [7:0]  cur_dx, cur_dy;
  logic        cur_bounce;
  logic [16:0] nx, ny;
  logic        out_x, out_y;
  logic [15:0] upd_x, upd_y;
  logic [7:0]  upd_dx, upd_dy;

  function automatic logic [7:0] neg_vel(input logic [7:0] v);
    // -128 has no positive twin in 8 bits; saturate to +127
    return (v == 8'h80) ? 8'h7f : (8'h00 - v);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      vs_meta <= i_v_sync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      vs_edge <= vs_sync & ~vs_prev;
    end
  end

  assign cfg_hit  = i_cfg_we && ({1'b0, i_cfg_idx} < 5'(NUM_SPRITES));
  assign cfg_slot = i_cfg_idx[IdxW-1:0];

  assign cur_x      = pos_x[idx];
  assign cur_y      = pos_y[idx];
  assign cur_hx     = home_x[idx];
  assign cur_hy     = home_y[idx];
  assign cur_dx     = vel_dx[idx];
  assign cur_dy     = vel_dy[idx];
  assign cur_bounce = bounce[idx];

  assign nx    = {1'b0, cur_x} + {{9{cur_dx[7]}}, cur_dx};
  assign ny    = {1'b0, cur_y} + {{9{cur_dy[7]}}, cur_dy};
  assign out_x = nx[16] || (nx[15:0] > MaxX);
  assign out_y = ny[16] || (ny[15:0] > MaxY);

  always_comb begin
    upd_x  = cur_x;
    upd_y  = cur_y;
    upd_dx = cur_dx;
    upd_dy = cur_dy;
    if (cur_bounce) begin
      if (out_x) upd_dx = neg_vel(cur_dx);
      else       upd_x  = nx[15:0];
      if (out_y) upd_dy = neg_vel(cur_dy);
      else       upd_y  = ny[15:0];
    end else if (out_x || out_y) begin
      upd_x = cur_hx;
      upd_y = cur_hy;
    end else begin
      upd_x = nx[15:0];
      upd_y = ny[15:0];
    end
  end

  // Config write is applied after the update so it wins on a same-slot collision
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
        pos_x[k]  <= '0;
        pos_y[k]  <= '0;
        home_x[k] <= '0;
        home_y[k] <= '0;
        vel_dx[k] <= '0;
        vel_dy[k] <= '0;
        bounce[k] <= 1'b0;
      end
    end else begin
      if (state == StUpdate) begin
        pos_x[idx]  <= upd_x;
        pos_y[idx]  <= upd_y;
        vel_dx[idx] <= upd_dx;
        vel_dy[idx] <= upd_dy;
      end
      if (cfg_hit) begin
        pos_x[cfg_slot]  <= i_cfg_x;
        pos_y[cfg_slot]  <= i_cfg_y;
        home_x[cfg_slot] <= i_cfg_x;
        home_y[cfg_slot] <= i_cfg_y;
        vel_dx[cfg_slot] <= i_cfg_dx;
        vel_dy[cfg_slot] <= i_cfg_dy;
        bounce[cfg_slot] <= i_cfg_bounce;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= StIdle;
      idx          <= '0;
      pending      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_overrun    <= 1'b0;
      o_pos_x      <= '0;
      o_pos_y      <= '0;
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!i_enable) begin
            pending <= 1'b0;
          end else if (vs_edge || pending) begin
            state   <= StUpdate;
            idx     <= '0;
            pending <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        StUpdate: begin
          if (idx == LastIdx) state <= StPublish;
          else                idx   <= idx + IdxW'(1);
        end
        StPublish: begin
          for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
            o_pos_x[16*k +: 16] <= pos_x[k];
            o_pos_y[16*k +: 16] <= pos_y[k];
          end
          o_frame_done <= 1'b1;
          o_frame_cnt  <= o_frame_cnt + 16'd1;
          o_busy       <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
      // One edge may queue behind a running pass; a second one is lost
      if (state != StIdle && vs_edge) begin
        if (pending) o_overrun <= 1'b1;
        else         pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed plus randomized bench for sprite_motion_ctrl against a per-frame behavioural model.
module tb_sprite_motion_ctrl;

  localparam int N    = 4;
  localparam int MAXX = 1280 - 128;
  localparam int MAXY = 720 - 128;

  logic            clk;
  logic            rst_n;
  logic            v_sync;
  logic            enable;
  logic            cfg_we;
  logic [3:0]      cfg_idx;
  logic [15:0]     cfg_x, cfg_y;
  logic [7:0]      cfg_dx, cfg_dy;
  logic            cfg_bounce;
  logic [16*N-1:0] pos_x, pos_y;
  logic            busy, frame_done, overrun;
  logic [15:0]     frame_cnt;

  int errors = 0;
  int checks = 0;

  int mx[N], my[N], mhx[N], mhy[N], mdx[N], mdy[N];
  bit mb[N];
  int pub_x[N], pub_y[N];
  int mcnt;
  bit movr;

  sprite_motion_ctrl #(.NUM_SPRITES(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_v_sync    (v_sync),
    .i_enable    (enable),
    .i_cfg_we    (cfg_we),
    .i_cfg_idx   (cfg_idx),
    .i_cfg_x     (cfg_x),
    .i_cfg_y     (cfg_y),
    .i_cfg_dx    (cfg_dx),
    .i_cfg_dy    (cfg_dy),
    .i_cfg_bounce(cfg_bounce),
    .o_pos_x     (pos_x),
    .o_pos_y     (pos_y),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_frame_cnt (frame_cnt),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap17(input int v);
    int r;
    r = v & 32'h1FFFF;
    if (r >= 65536) r -= 131072;
    return r;
  endfunction

  function automatic int negv(input int d);
    return (d == -128) ? 127 : -d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = 0; my[k] = 0; mhx[k] = 0; mhy[k] = 0; mdx[k] = 0; mdy[k] = 0; mb[k] = 0;
      pub_x[k] = 0; pub_y[k] = 0;
    end
    mcnt = 0;
    movr = 0;
  endtask

  task automatic model_cfg(input int k, input int x, input int y, input int dx, input int dy,
                           input bit b);
    if (k < N) begin
      mx[k] = x; my[k] = y; mhx[k] = x; mhy[k] = y; mdx[k] = dx; mdy[k] = dy; mb[k] = b;
    end
  endtask

  // One frame: each slot moves by its velocity, edge handling by mode, then publish
  task automatic model_pass(input int skip);
    int nx, ny;
    bit ox, oy;
    for (int k = 0; k < N; k++) begin
      if (k != skip) begin
        nx = wrap17(mx[k] + mdx[k]);
        ny = wrap17(my[k] + mdy[k]);
        ox = (nx < 0) || (nx > MAXX);
        oy = (ny < 0) || (ny > MAXY);
        if (mb[k]) begin
          if (ox) mdx[k] = negv(mdx[k]); else mx[k] = nx;
          if (oy) mdy[k] = negv(mdy[k]); else my[k] = ny;
        end else if (ox || oy) begin
          mx[k] = mhx[k];
          my[k] = mhy[k];
        end else begin
          mx[k] = nx;
          my[k] = ny;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      pub_x[k] = mx[k];
      pub_y[k] = my[k];
    end
    mcnt = (mcnt + 1) & 16'hFFFF;
  endtask

  task automatic cfg_write(input int k, input int x, input int y, input int dx, input int dy,
                           input bit b);
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_idx    = 4'(k);
    cfg_x      = 16'(x);
    cfg_y      = 16'(y);
    cfg_dx     = 8'(dx);
    cfg_dy     = 8'(dy);
    cfg_bounce = b;
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(k, x, y, dx, dy, b);
  endtask

  // Single vsync pulse, then a fixed observation window counting frame_done pulses
  task automatic vsync_frame(output int pulses);
    @(negedge clk);
    v_sync = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) v_sync = 1'b0;
      if (frame_done) pulses++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_x%0d", tag, k), int'(pos_x[16*k +: 16]), pub_x[k]);
      chk($sformatf("%s_y%0d", tag, k), int'(pos_y[16*k +: 16]), pub_y[k]);
    end
    chk($sformatf("%s_cnt", tag), int'(frame_cnt), mcnt);
    chk($sformatf("%s_ovr", tag), int'(overrun), int'(movr));
    chk($sformatf("%s_busy", tag), int'(busy), 0);
  endtask

  initial begin
    int p;
    int nw;
    rst_n = 1'b0; v_sync = 1'b0; enable = 1'b1; cfg_we = 1'b0; cfg_idx = '0;
    cfg_x = '0; cfg_y = '0; cfg_dx = '0; cfg_dy = '0; cfg_bounce = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    chk("reset_done", int'(frame_done), 0);

    // Respawn: in range up to MAX_X, then past it back to home
    cfg_write(0, 1151, 300, 1, 1, 1'b0);
    vsync_frame(p); model_pass(-1);
    chk("p1_pulses", p, 1);
    check_all("p1");
    chk("p1_x0_lit", int'(pos_x[15:0]), 1152);
    chk("p1_y0_lit", int'(pos_y[15:0]), 301);
    vsync_frame(p); model_pass(-1);
    check_all("p2");
    chk("p2_x0_home", int'(pos_x[15:0]), 1151);
    cfg_write(0, 876, 96, 0, -128, 1'b0);
    vsync_frame(p); model_pass(-1);
    check_all("p3");
    chk("p3_x0_home", int'(pos_x[15:0]), 876);
    chk("p3_y0_home", int'(pos_y[15:0]), 96);

    // Bounce at the left edge, including -128 -> +127
    cfg_write(1, 0, 10, -3, 0, 1'b1);
    vsync_frame(p); model_pass(-1);
    check_all("b1");
    chk("b1_x1_lit", int'(pos_x[31:16]), 0);
    vsync_frame(p); model_pass(-1);
    check_all("b2");
    chk("b2_x1_lit", int'(pos_x[31:16]), 3);
    cfg_write(1, 0, 10, -128, 0, 1'b1);
    vsync_frame(p); model_pass(-1);
    chk("b3_x1_lit", int'(pos_x[31:16]), 0);
    vsync_frame(p); model_pass(-1);
    check_all("b4");
    chk("b4_x1_lit", int'(pos_x[31:16]), 127);

    // Paused: vsync edges ignored
    enable = 1'b0;
    vsync_frame(p);
    vsync_frame(p);
    chk("pause_pulses", p, 0);
    check_all("pause");
    enable = 1'b1;

    // Config write to slot 2 in the cycle slot 2 is being updated
    @(negedge clk);
    v_sync = 1'b1;
    p = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) v_sync = 1'b0;
      if (i == 6) begin
        cfg_we = 1'b1; cfg_idx = 4'd2; cfg_x = 16'd500; cfg_y = 16'd200;
        cfg_dx = 8'd5; cfg_dy = 8'd5; cfg_bounce = 1'b0;
      end
      if (i == 7) cfg_we = 1'b0;
      if (frame_done) p++;
    end
    model_cfg(2, 500, 200, 5, 5, 1'b0);
    model_pass(2);
    chk("col_pulses", p, 1);
    check_all("col");
    chk("col_x2_lit", int'(pos_x[47:32]), 500);
    chk("col_y2_lit", int'(pos_y[47:32]), 200);
    vsync_frame(p); model_pass(-1);
    check_all("col_next");

    // Reset in the middle of UPDATE
    @(negedge clk);
    v_sync = 1'b1;
    p = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) v_sync = 1'b0;
      if (i == 5) rst_n = 1'b0;
      if (i == 7) rst_n = 1'b1;
      if (frame_done) p++;
    end
    model_reset();
    chk("rst_pulses", p, 0);
    check_all("rst");
    cfg_write(3, 100, 100, 2, -2, 1'b1);
    vsync_frame(p); model_pass(-1);
    chk("rst_next_pulses", p, 1);
    check_all("rst_next");

    // Three edges two cycles apart: one runs, one queues, one overruns
    @(negedge clk);
    v_sync = 1'b1;
    p = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1 || i == 3 || i == 5) v_sync = 1'b0;
      if (i == 2 || i == 4) v_sync = 1'b1;
      if (frame_done) p++;
    end
    model_pass(-1);
    model_pass(-1);
    movr = 1'b1;
    chk("ovr_pulses", p, 2);
    check_all("ovr");
    chk("ovr_cnt_lit", int'(frame_cnt), 3);

    // Randomized configuration and frames
    for (int it = 0; it < 25; it++) begin
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        cfg_write(int'($urandom_range(0, 5)), int'($urandom_range(0, 1300)),
                  int'($urandom_range(0, 800)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      end
      vsync_frame(p); model_pass(-1);
      chk($sformatf("rnd%0d_pulses", it), p, 1);
      check_all($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame motion scheduler for the on-screen sprite set (glacier, player and similar). It holds position, velocity, home and edge-mode state for NUM_SPRITES slots. On each enabled vsync rising edge it updates every slot once, serially, through one shared adder/bounds-checker. It then publishes a consistent, double-buffered set of positions to the sprite renderers.

Parameters:
NUM_SPRITES, 4, number of sprite slots (1..16)
SCREEN_W, 1280, active width in pixels
SCREEN_H, 720, active height in pixels
SPRITE_SIZE, 128, rendered sprite edge in pixels; MAX_X = SCREEN_W-SPRITE_SIZE, MAX_Y = SCREEN_H-SPRITE_SIZE

Ports:
i_clk  in  1  pixel clock, the only clock
i_rst_n  in  1  asynchronous active-low reset
i_v_sync  in  1  vsync from the timing generator, treated as asynchronous
i_enable  in  1  1 = run motion; 0 = vsync edges ignored (pause)
i_cfg_we  in  1  config write strobe, one cycle
i_cfg_idx  in  4  target slot; values >= NUM_SPRITES are ignored
i_cfg_x, i_cfg_y  in  16 each  position and home to load
i_cfg_dx, i_cfg_dy  in  8 each  signed velocity in pixels/frame
i_cfg_bounce  in  1  edge mode: 0 = respawn at home, 1 = bounce
o_pos_x, o_pos_y  out  16*NUM_SPRITES each  published positions, slot k at bits [16k+15:16k]
o_busy  out  1  high while an update pass runs
o_frame_done  out  1  one-cycle pulse when a new position set is published
o_frame_cnt  out  16  completed passes, wraps at 0xFFFF->0
o_overrun  out  1  sticky: vsync edge arrived while a pass was busy and one was already pending

Behaviour:
- Reset clears all slot state, the published outputs, the counter, the flags and the FSM. FSM enters IDLE.
- Vsync handling: 2-FF synchroniser, then a rising-edge detect register. The edge is visible 3 i_clk cycles after i_v_sync rises.
- FSM IDLE: on (edge or pending) with i_enable=1, go to UPDATE with idx=0 and clear pending. If i_enable=0, edges are dropped and pending is cleared.
- FSM UPDATE: one slot per cycle, idx = 0..NUM_SPRITES-1, then go to PUBLISH. o_busy=1 in UPDATE and PUBLISH.
- FSM PUBLISH: copy the working positions to o_pos_x/o_pos_y, pulse o_frame_done, increment o_frame_cnt, return to IDLE.
- Pass latency: NUM_SPRITES+1 cycles from UPDATE entry to the o_frame_done pulse.
- Per-slot arithmetic: nx = {1'b0,x} + sext17(dx), computed as a 17-bit signed value; ny is computed the same way.
- An axis is out of range if nx < 0 or nx > MAX_X (ny uses MAX_Y).
- Respawn mode: if either axis is out of range, x,y <= home_x,home_y and the velocity is unchanged.
- Bounce mode, per axis independently: if out of range, that position holds and its velocity is negated. Negating -128 yields +127.
- In-range axes take the new value, so position == MAX is legal.
- Config write: loads x, y, home_x, home_y, dx, dy and mode for the slot in the same cycle. It takes effect in the working set only; published outputs change at the next PUBLISH.
- Config write to the slot being updated in the same cycle: the write wins and the update for that slot is discarded.
- Writes to slots already or not yet processed in the current pass are simply stored. Later slots use the new values this pass.
- Edge during UPDATE/PUBLISH: set pending, and run the next pass immediately after return to IDLE. If pending is already set, the edge is dropped and o_overrun is set. o_overrun is cleared only by reset.
- Reset mid-pass: everything returns to reset values and no partial publish occurs.
- i_enable falling mid-pass: the current pass completes.

Test Plan:
- Reset, then cfg slot0 x=1151 y=300 dx=1 dy=1 respawn, and raise vsync -> after one pass o_pos slot0 = (1152,301), o_frame_done one pulse, o_frame_cnt=1.
- Continue from above, next vsync -> x would be 1153 > 1152, so slot0 = home (1151,300). Second vsync with home (876,96) loaded -> (876,96).
- Bounce slot1 x=0 y=10 dx=-3 dy=0, vsync -> slot1 x stays 0 and dx becomes +3; next vsync -> x=3. Repeat with dx=-128 -> dx becomes +127.
- Three vsync edges 2 cycles apart during a pass with NUM_SPRITES=4 -> exactly 2 passes, o_overrun=1, o_frame_cnt=2.
- Cfg write to slot2 in the exact UPDATE cycle of idx=2 -> slot2 publishes the written x/y unchanged. i_enable=0 with vsync edges -> o_frame_cnt constant, no o_frame_done pulse.
- i_rst_n low during UPDATE -> outputs zero, FSM IDLE, no o_frame_done pulse. The next enabled vsync starts a clean pass.
